// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path: register geometry,
// requester indices, and the round-robin wrap helper.
package regfile_pkg;

  localparam int REG_AW = 5;
  localparam int NREG   = 32;
  localparam int XLEN   = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_CSR  = 2;
  localparam int WB_NREQ  = REQ_CSR + 1;

  function automatic int unsigned rr_wrap(int unsigned base, int unsigned off, int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback requester bus, issue-stage scoreboard signals and the register-file write port.
interface regfile_wb_scheduler_if
  import regfile_pkg::*;
#(
  parameter int W    = XLEN,
  parameter int AW   = REG_AW,
  parameter int NREQ = WB_NREQ
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*W-1:0]  req_data;
  logic               rsv_valid;
  logic [AW-1:0]      rsv_rd;
  logic [AW-1:0]      rs1;
  logic [AW-1:0]      rs2;
  logic               hazard;
  logic [NREG-1:0]    busy;
  logic [AW-1:0]      rf_rd;
  logic [W-1:0]       rf_data;
  logic               rf_we;

  modport master (
    output req_valid, req_rd, req_data, rsv_valid, rsv_rd, rs1, rs2,
    input  req_ready, hazard, busy, rf_rd, rf_data, rf_we
  );

  modport slave (
    input  req_valid, req_rd, req_data, rsv_valid, rsv_rd, rs1, rs2,
    output req_ready, hazard, busy, rf_rd, rf_data, rf_we
  );
endinterface

// File: rtl/regfile_wb_scheduler_arbiter.sv
// Round-robin arbiter: one-hot grant among requests, search starting at rr_ptr;
// the pointer moves just past the winner whenever a grant is issued.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = WB_NREQ,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clock_signal,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            grant_valid
);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'(rr_wrap(int'(rr_ptr), k, NREQ));
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_signal or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= PW'(rr_wrap(int'(grant_idx), 1, NREQ));
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the single register-file write port among ALU/LOAD/CSR writebacks
// through one-entry holding slots, and tracks outstanding destinations.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int W    = XLEN,
  parameter int AW   = REG_AW,
  parameter int NREQ = WB_NREQ
) (
  input logic                   clock_signal,
  input logic                   reset,
  regfile_wb_scheduler_if.slave bus
);

  logic [NREQ-1:0] full;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] fill;
  logic            grant_valid;
  logic [AW-1:0]   slot_rd   [NREQ];
  logic [W-1:0]    slot_data [NREQ];
  logic [AW-1:0]   wb_rd;
  logic [W-1:0]    wb_data;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clock_signal (clock_signal),
    .reset        (reset),
    .req          (full),
    .grant        (grant),
    .grant_valid  (grant_valid)
  );

  // A slot being drained this cycle can take a new entry on the same edge.
  assign ready = ~full | grant;
  assign fill  = bus.req_valid & ready;

  always_ff @(posedge clock_signal or negedge reset) begin
    if (!reset) begin
      full <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_rd[i]   <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (fill[i]) begin
          full[i]      <= |bus.req_rd[i*AW +: AW];
          slot_rd[i]   <= bus.req_rd[i*AW +: AW];
          slot_data[i] <= bus.req_data[i*W +: W];
        end else if (grant[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    wb_rd   = '0;
    wb_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        wb_rd   = slot_rd[i];
        wb_data = slot_data[i];
      end
    end
  end

  // Clear before set so a same-edge re-reservation keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (grant_valid) busy_d[wb_rd] = 1'b0;
    if (bus.rsv_valid && (bus.rsv_rd != '0)) busy_d[bus.rsv_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock_signal or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign bus.req_ready = ready;
  assign bus.rf_we     = grant_valid;
  assign bus.rf_rd     = wb_rd;
  assign bus.rf_data   = wb_data;
  assign bus.busy      = busy_q;
  assign bus.hazard    = busy_q[bus.rs1] | busy_q[bus.rs2] | busy_q[bus.rsv_rd];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboarded bench: directed writebacks push expected (rd,data) pairs; a negedge
// monitor pops and compares on every rf_we, alongside directed scoreboard checks.
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  logic clock_signal = 1'b0;
  logic reset        = 1'b0;
  always #5 clock_signal = ~clock_signal;

  regfile_wb_scheduler_if bus_if ();

  regfile_wb_scheduler dut (
    .clock_signal (clock_signal),
    .reset        (reset),
    .bus          (bus_if)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  tests = 0;
  int  fails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock_signal) begin
    if (reset && bus_if.rf_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: rd=%0d data=0x%0h with nothing expected",
                 bus_if.rf_rd, bus_if.rf_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_rd", 32'(bus_if.rf_rd), 32'(mon_e.rd));
        chk("wb_data", bus_if.rf_data, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clock_signal);
    #1;
  endtask

  task automatic idle_req();
    bus_if.req_valid = '0;
    bus_if.rsv_valid = 1'b0;
    bus_if.rsv_rd    = '0;
  endtask

  task automatic drive_req(int i, logic [4:0] rd, logic [31:0] d, bit expect_write);
    bus_if.req_valid[i]       = 1'b1;
    bus_if.req_rd[i*5 +: 5]   = rd;
    bus_if.req_data[i*32 +: 32] = d;
    if (expect_write) exp_q.push_back('{rd: rd, data: d});
  endtask

  task automatic wait_drain(string name);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(negedge clock_signal);
      #1;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.req_valid = '0;
    bus_if.req_rd    = '0;
    bus_if.req_data  = '0;
    bus_if.rsv_valid = 1'b0;
    bus_if.rsv_rd    = '0;
    bus_if.rs1       = '0;
    bus_if.rs2       = '0;

    // Reset state
    #12;
    chk("rst_rf_we", 32'(bus_if.rf_we), 32'd0);
    chk("rst_rf_rd", 32'(bus_if.rf_rd), 32'd0);
    chk("rst_rf_data", bus_if.rf_data, 32'd0);
    chk("rst_busy", bus_if.busy, 32'd0);
    chk("rst_ready", 32'(bus_if.req_ready), 32'h7);
    #5 reset = 1'b1;
    tick();
    chk("ready_after_reset", 32'(bus_if.req_ready), 32'h7);

    // 1. Single ALU write with reservation of x5
    drive_req(REQ_ALU, 5'd5, 32'hDEADBEEF, 1'b1);
    bus_if.rsv_valid = 1'b1;
    bus_if.rsv_rd    = 5'd5;
    tick();
    idle_req();
    chk("t1_we", 32'(bus_if.rf_we), 32'd1);
    chk("t1_rd", 32'(bus_if.rf_rd), 32'd5);
    chk("t1_busy_set", bus_if.busy, 32'h0000_0020);
    tick();
    chk("t1_busy_clear", bus_if.busy, 32'd0);
    chk("t1_we_low", 32'(bus_if.rf_we), 32'd0);
    wait_drain("t1_drain");

    // 3. x0 write is accepted but dropped
    drive_req(REQ_LOAD, 5'd0, 32'h1234, 1'b0);
    chk("t3_ready", 32'(bus_if.req_ready[REQ_LOAD]), 32'd1);
    tick();
    idle_req();
    chk("t3_no_we", 32'(bus_if.rf_we), 32'd0);
    chk("t3_busy", bus_if.busy, 32'd0);
    tick();
    chk("t3_no_we2", 32'(bus_if.rf_we), 32'd0);

    // 4. Scoreboard hazard on x7
    bus_if.rsv_valid = 1'b1;
    bus_if.rsv_rd    = 5'd7;
    tick();
    idle_req();
    bus_if.rs2 = 5'd7;
    chk("t4_hazard_rs2", 32'(bus_if.hazard), 32'd1);
    bus_if.rs2 = 5'd0;
    bus_if.rs1 = 5'd7;
    chk("t4_busy7", bus_if.busy, 32'h0000_0080);
    tick();
    chk("t4_hazard_hold", 32'(bus_if.hazard), 32'd1);
    drive_req(REQ_ALU, 5'd7, 32'h77, 1'b1);
    tick();
    idle_req();
    bus_if.rsv_valid = 1'b1;
    bus_if.rsv_rd    = 5'd7;
    chk("t4_we", 32'(bus_if.rf_we), 32'd1);
    tick();
    idle_req();
    chk("t4_set_wins", bus_if.busy, 32'h0000_0080);
    chk("t4_hazard_still", 32'(bus_if.hazard), 32'd1);
    drive_req(REQ_ALU, 5'd7, 32'h78, 1'b1);
    tick();
    idle_req();
    tick();
    chk("t4_busy_clear", bus_if.busy, 32'd0);
    chk("t4_hazard_clear", 32'(bus_if.hazard), 32'd0);
    bus_if.rs1 = 5'd0;
    wait_drain("t4_drain");

    // 6. Back-to-back CSR writes, one per cycle
    for (int k = 0; k < 4; k++) begin
      drive_req(REQ_CSR, 5'(10 + k), 32'hC000_0000 + 32'(10 + k), 1'b1);
      chk("t6_ready", 32'(bus_if.req_ready[REQ_CSR]), 32'd1);
      tick();
      chk("t6_we", 32'(bus_if.rf_we), 32'd1);
      chk("t6_rd", 32'(bus_if.rf_rd), 32'(10 + k));
    end
    idle_req();
    tick();
    chk("t6_we_low", 32'(bus_if.rf_we), 32'd0);
    wait_drain("t6_drain");

    // 2. Round-robin contention from rr_ptr=0, with immediate ALU refill
    drive_req(REQ_ALU,  5'd1, 32'hA1, 1'b1);
    drive_req(REQ_LOAD, 5'd2, 32'hA2, 1'b1);
    drive_req(REQ_CSR,  5'd3, 32'hA3, 1'b1);
    tick();
    idle_req();
    drive_req(REQ_ALU, 5'd4, 32'hA4, 1'b1);
    chk("t2_alu_refill_ready", 32'(bus_if.req_ready[REQ_ALU]), 32'd1);
    tick();
    idle_req();
    wait_drain("t2_drain");

    // 5. Reset mid-operation (rr_ptr is 1 here)
    drive_req(REQ_ALU,  5'd9,  32'h90, 1'b0);
    drive_req(REQ_LOAD, 5'd10, 32'h91, 1'b0);
    drive_req(REQ_CSR,  5'd11, 32'h92, 1'b0);
    bus_if.rsv_valid = 1'b1;
    bus_if.rsv_rd    = 5'd9;
    tick();
    idle_req();
    chk("t5_busy9", bus_if.busy, 32'h0000_0200);
    #1 reset = 1'b0;
    #1;
    chk("t5_we_withdrawn", 32'(bus_if.rf_we), 32'd0);
    chk("t5_busy_rst", bus_if.busy, 32'd0);
    chk("t5_ready_rst", 32'(bus_if.req_ready), 32'h7);
    @(negedge clock_signal);
    #1 reset = 1'b1;
    tick();
    chk("t5_we_after", 32'(bus_if.rf_we), 32'd0);
    chk("t5_busy_after", bus_if.busy, 32'd0);
    drive_req(REQ_ALU,  5'd1, 32'hB1, 1'b1);
    drive_req(REQ_LOAD, 5'd2, 32'hB2, 1'b1);
    drive_req(REQ_CSR,  5'd3, 32'hB3, 1'b1);
    tick();
    idle_req();
    chk("t5_ptr0_first_rd", 32'(bus_if.rf_rd), 32'd1);
    wait_drain("t5_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
